// File: rtl/retardo.sv
`default_nettype none
// ============================================================================
// Module   : retardo
// Brief    : DEPTH-stage N-bit enabled delay line with async active-low reset.
//            Optional 'filled' status port enabled by macro RETARDO_FILLED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module retardo #(
    parameter int N     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [N-1:0] datain,
    output logic [N-1:0] dataout
`ifdef RETARDO_FILLED_EN
    ,
    output logic         filled
`endif
);

    generate
        if (DEPTH == 0) begin : g_passthru
            // Zero-stage line is a wire; clock, reset and enable are irrelevant.
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst, enable};
            assign dataout  = datain;
`ifdef RETARDO_FILLED_EN
            assign filled   = 1'b1;
`endif
        end else begin : g_chain
            logic [N-1:0] r_stage [DEPTH];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        r_stage[k] <= '0;
                    end
                end else if (enable) begin
                    r_stage[0] <= datain;
                    for (int k = 1; k < DEPTH; k++) begin
                        r_stage[k] <= r_stage[k-1];
                    end
                end
            end

            assign dataout = r_stage[DEPTH-1];

`ifdef RETARDO_FILLED_EN
            // Saturating count of enabled edges since reset; stops at DEPTH.
            localparam int                C_CW   = $clog2(DEPTH + 1);
            localparam logic [C_CW-1:0]   c_full = C_CW'(DEPTH);
            logic [C_CW-1:0]              r_count;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_count <= '0;
                end else if (enable && (r_count != c_full)) begin
                    r_count <= r_count + C_CW'(1);
                end
            end

            assign filled = (r_count == c_full);
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_retardo.sv
`default_nettype none
// Directed self-checking bench for retardo: DEPTH 1/4/3 lines share clock,
// reset, enable and data; a 16-bit DEPTH 0 instance checks the pass-through.
module tb_retardo;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  din;
    logic [15:0] d0_in;
    logic [7:0]  d1_out, d4_out, d3_out;
    logic [15:0] d0_out;
`ifdef RETARDO_FILLED_EN
    logic        d1_filled, d4_filled, d3_filled, d0_filled;
`endif

    int chk_count = 0;
    int err_count = 0;

    always #5 clk = ~clk;

    retardo #(8, 1) u_d1 (
        .clk(clk), .rst(rst), .enable(enable), .datain(din), .dataout(d1_out)
`ifdef RETARDO_FILLED_EN
        , .filled(d1_filled)
`endif
    );

    retardo #(.N(8), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .enable(enable), .datain(din), .dataout(d4_out)
`ifdef RETARDO_FILLED_EN
        , .filled(d4_filled)
`endif
    );

    retardo #(.N(8), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .enable(enable), .datain(din), .dataout(d3_out)
`ifdef RETARDO_FILLED_EN
        , .filled(d3_filled)
`endif
    );

    retardo #(.N(16), .DEPTH(0)) u_d0 (
        .clk(clk), .rst(rst), .enable(enable), .datain(d0_in), .dataout(d0_out)
`ifdef RETARDO_FILLED_EN
        , .filled(d0_filled)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_count++;
        if (obs !== exp) begin
            err_count++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse placed between clock edges.
    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b0;
        enable = 1'b1;
        din    = 8'd77;
        d0_in  = 16'h0000;
        #1;
        check("reset_d1", 32'(d1_out), 32'd0);
        check("reset_d4", 32'(d4_out), 32'd0);

        // DEPTH=1: reset held over several edges, then 0 then 10.
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst_hold_d1_%0d", i), 32'(d1_out), 32'd0);
        end
        check("rst_hold_d3", 32'(d3_out), 32'd0);
        rst = 1'b1;
        din = 8'd0;
        step();
        check("d1_zero", 32'(d1_out), 32'd0);
        din = 8'd10;
        check("d1_before_edge", 32'(d1_out), 32'd0);
        step();
        check("d1_ten", 32'(d1_out), 32'd10);

        // DEPTH=4 / DEPTH=3 ramp latency.
        pulse_reset();
        for (int i = 1; i <= 10; i++) begin
            din = 8'(i);
            step();
            check($sformatf("ramp_d4_%0d", i), 32'(d4_out), (i >= 4) ? 32'(i - 3) : 32'd0);
            check($sformatf("ramp_d3_%0d", i), 32'(d3_out), (i >= 3) ? 32'(i - 2) : 32'd0);
        end

        // Enable gap: 5,6,7 in, three disabled edges with 99 on the input.
        pulse_reset();
        for (int i = 5; i <= 7; i++) begin
            din = 8'(i);
            step();
        end
        check("gap_pre_d4", 32'(d4_out), 32'd0);
        check("gap_pre_d3", 32'(d3_out), 32'd5);
        enable = 1'b0;
        din    = 8'd99;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("gap_hold_d4_%0d", i), 32'(d4_out), 32'd0);
            check($sformatf("gap_hold_d3_%0d", i), 32'(d3_out), 32'd5);
        end
        enable = 1'b1;
        for (int i = 8; i <= 11; i++) begin
            din = 8'(i);
            step();
            check($sformatf("gap_out_d4_%0d", i), 32'(d4_out), 32'(i - 3));
            if (i <= 10) begin
                check($sformatf("gap_out_d3_%0d", i), 32'(d3_out), 32'(i - 2));
            end
        end

        // Asynchronous reset between edges on a populated line, then refill.
        check("pre_async_d3", 32'(d3_out), 32'd9);
        rst = 1'b0;
        #1;
        check("async_rst_d3", 32'(d3_out), 32'd0);
        check("async_rst_d4", 32'(d4_out), 32'd0);
        check("async_rst_d1", 32'(d1_out), 32'd0);
`ifdef RETARDO_FILLED_EN
        check("filled_in_rst", 32'(d3_filled), 32'd0);
`endif
        rst = 1'b1;
        #1;
        check("after_release_d3", 32'(d3_out), 32'd0);
`ifdef RETARDO_FILLED_EN
        check("filled_after_rst", 32'(d3_filled), 32'd0);
`endif
        for (int i = 1; i <= 4; i++) begin
            din = 8'(20 + i);
            step();
            check($sformatf("refill_d3_%0d", i), 32'(d3_out), (i >= 3) ? 32'(18 + i) : 32'd0);
`ifdef RETARDO_FILLED_EN
            check($sformatf("filled_edge_%0d", i), 32'(d3_filled), (i >= 3) ? 32'd1 : 32'd0);
`endif
        end
`ifdef RETARDO_FILLED_EN
        enable = 1'b0;
        step();
        step();
        check("filled_hold_disabled", 32'(d3_filled), 32'd1);
        check("filled_d4_partial", 32'(d4_filled), 32'd1);
        rst = 1'b0;
        #1;
        check("filled_clr_d3", 32'(d3_filled), 32'd0);
        check("filled_d0_const", 32'(d0_filled), 32'd1);
        rst    = 1'b1;
        enable = 1'b1;
        #1;
`endif

        // DEPTH=0 pass-through, including under reset and with enable low.
        d0_in = 16'hABCD;
        #1;
        check("d0_pass", 32'(d0_out), 32'h0000ABCD);
        rst    = 1'b0;
        enable = 1'b0;
        d0_in  = 16'h1234;
        #1;
        check("d0_pass_rst", 32'(d0_out), 32'h00001234);
        d0_in = 16'hABCD;
        step();
        check("d0_pass_rst_edge", 32'(d0_out), 32'h0000ABCD);
        rst = 1'b1;

        $display("Result: errors=%0d of %0d checks", err_count, chk_count);
        $finish;
    end

endmodule
`default_nettype wire
